// File: rtl/tb_mem_arb_pkg.sv
// Shared types for the testbench SRAM arbiter.
// Optional stats build: define TB_MEM_ARB_STATS_EN.
package tb_mem_arb_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int ADDR_WIDTH   = 15;
    localparam int MAX_LOCK_DEF = 16;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] be;
    } mem_req_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/tb_mem_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module tb_mem_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter with bounded lock sharing one single-port SRAM.
// Define TB_MEM_ARB_STATS_EN to add grant and forced-release counters.
module tb_mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 15,
    parameter int MAX_LOCK   = tb_mem_arb_pkg::MAX_LOCK_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              lock_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]         mem_be_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
`ifdef TB_MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]           stat_gnt_o,
    output logic [15:0]                     stat_forced_o
`endif
);

    import tb_mem_arb_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    arb_state_e         state;
    logic [IW-1:0]      owner;
    logic [IW-1:0]      ptr;
    logic [7:0]         cnt;
    logic [NUM_REQ-1:0] rvalid_q;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IW-1:0]      rr_idx;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      ptr_nxt;
    logic               locked;
    logic               lock_hold;
    logic               forced;
    logic               any_gnt;

    tb_mem_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_i),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    // Forced release falls through to round-robin; ptr already sits at owner+1.
    assign locked    = (state == ARB_LOCKED);
    assign lock_hold = locked && req_i[owner] && (cnt < MAX_CNT);
    assign forced    = locked && req_i[owner] && !lock_hold;
    assign gnt_o     = lock_hold ? (NUM_REQ'(1) << owner) : rr_gnt;
    assign gidx      = lock_hold ? owner : rr_idx;
    assign any_gnt   = |gnt_o;
    assign ptr_nxt   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_o[k]) begin
                mem_we_o    = we_i[k];
                mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                mem_be_o    = be_i[k*BW +: BW];
            end
        end
    end

    assign mem_req_o = any_gnt;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt_o;
            if (any_gnt)
                ptr <= ptr_nxt;
            if (lock_hold) begin
                if (lock_i[owner]) begin
                    cnt <= cnt + 8'd1;
                end else begin
                    state <= ARB_IDLE;
                    cnt   <= '0;
                end
            end else if (any_gnt && lock_i[gidx]) begin
                state <= ARB_LOCKED;
                owner <= gidx;
                cnt   <= 8'd1;
            end else begin
                state <= ARB_IDLE;
                cnt   <= '0;
            end
        end
    end

`ifdef TB_MEM_ARB_STATS_EN
    logic [31:0] gcnt [NUM_REQ];
    logic [15:0] fcnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REQ; k++)
                gcnt[k] <= '0;
            fcnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++)
                if (gnt_o[k] && (gcnt[k] != 32'hFFFF_FFFF))
                    gcnt[k] <= gcnt[k] + 32'd1;
            if (forced && (fcnt != 16'hFFFF))
                fcnt <= fcnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_gnt_o[g*32 +: 32] = gcnt[g];
    end
    assign stat_forced_o = fcnt;
`endif

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter with a behavioural 1-cycle SRAM.
// Stats checks are compiled in when TB_MEM_ARB_STATS_EN is defined.
module tb_tb_mem_arbiter;

    import tb_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  lock = '0;
    mem_req_t    r0 = '0;
    mem_req_t    r1 = '0;

    logic [1:0]   we;
    logic [29:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  be;
    logic [1:0]   gnt;
    logic [1:0]   rvalid;
    logic [63:0]  rdata;
    logic         mem_req;
    logic         mem_we;
    logic [14:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_be;
    logic [63:0]  sram_q = '0;
`ifdef TB_MEM_ARB_STATS_EN
    logic [63:0]  stat_gnt;
    logic [15:0]  stat_forced;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] sram [0:32767];

    assign we    = {r1.we, r0.we};
    assign addr  = {r1.addr, r0.addr};
    assign wdata = {r1.wdata, r0.wdata};
    assign be    = {r1.be, r0.be};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b])
                        sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                sram_q <= sram[mem_addr];
            end
        end
    end

    tb_mem_arbiter #(
        .NUM_REQ    (2),
        .DATA_WIDTH (64),
        .ADDR_WIDTH (15),
        .MAX_LOCK   (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (sram_q)
`ifdef TB_MEM_ARB_STATS_EN
        ,
        .stat_gnt_o    (stat_gnt),
        .stat_forced_o (stat_forced)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        lock = '0;
        tick();
        tick();
        n_cmp++;
        if (gnt !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_gnt: got %b want 00", gnt);
        end
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
        n_cmp++;
        if (rvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_rvalid: got %b want 00", rvalid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read;
        r0.we = 1'b0;
        r0.addr = 15'h800;
        req = 2'b01;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL read_gnt: got %b want 01", gnt);
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 15'h800 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL read_mux: got req=%b addr=%h we=%b want 1 800 0",
                     mem_req, mem_addr, mem_we);
        end
        tick();
        req = 2'b00;
        #1;
        n_cmp++;
        if (rvalid !== 2'b01) begin
            n_bad++;
            $display("FAIL read_rvalid: got %b want 01", rvalid);
        end
        n_cmp++;
        if (rdata !== 64'h539) begin
            n_bad++;
            $display("FAIL read_rdata: got %h want 539", rdata);
        end
        n_cmp++;
        if (gnt !== 2'b00 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL read_idle: got gnt=%b req=%b want 00 0", gnt, mem_req);
        end
    endtask

    // Pointer is 1 after the single read, so rotation starts at requester 1.
    task automatic test_rotation;
        logic [1:0] exp [7];
        exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        r0.addr = 15'h0;
        r1.addr = 15'h0;
        for (int i = 0; i < 7; i++) begin
            req = 2'b11;
            #1;
            n_cmp++;
            if (gnt !== exp[i]) begin
                n_bad++;
                $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, exp[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (rvalid !== exp[i-1]) begin
                    n_bad++;
                    $display("FAIL rot_rvalid[%0d]: got %b want %b",
                             i, rvalid, exp[i-1]);
                end
            end
            tick();
        end
        req = 2'b00;
        #1;
        n_cmp++;
        if (rvalid !== exp[6]) begin
            n_bad++;
            $display("FAIL rot_rvalid_last: got %b want %b", rvalid, exp[6]);
        end
        tick();
    endtask

    task automatic test_write_read;
        r0.we = 1'b1;
        r0.addr = 15'h10;
        r0.wdata = 64'hDEAD_BEEF;
        r0.be = 8'h0F;
        r1.we = 1'b0;
        r1.addr = 15'h10;
        req = 2'b11;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL wr_gnt: got %b want 01", gnt);
        end
        n_cmp++;
        if (mem_we !== 1'b1 || mem_wdata !== 64'hDEAD_BEEF || mem_be !== 8'h0F) begin
            n_bad++;
            $display("FAIL wr_mux: got we=%b wdata=%h be=%h want 1 deadbeef 0f",
                     mem_we, mem_wdata, mem_be);
        end
        tick();
        req = 2'b10;
        #1;
        n_cmp++;
        if (gnt !== 2'b10 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_gnt: got gnt=%b we=%b want 10 0", gnt, mem_we);
        end
        n_cmp++;
        if (rvalid !== 2'b01) begin
            n_bad++;
            $display("FAIL wr_rvalid: got %b want 01", rvalid);
        end
        tick();
        req = 2'b00;
        r0.we = 1'b0;
        #1;
        n_cmp++;
        if (rvalid !== 2'b10) begin
            n_bad++;
            $display("FAIL rd_rvalid: got %b want 10", rvalid);
        end
        n_cmp++;
        if (rdata !== 64'hAABB_CCDD_DEAD_BEEF) begin
            n_bad++;
            $display("FAIL rd_data: got %h want aabbccdddeadbeef", rdata);
        end
        tick();
    endtask

    task automatic test_lock;
        logic [1:0] exp [6];
        exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 6; i++) begin
            req = 2'b11;
            lock = 2'b01;
            #1;
            n_cmp++;
            if (gnt !== exp[i]) begin
                n_bad++;
                $display("FAIL lock_gnt[%0d]: got %b want %b", i, gnt, exp[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (rvalid !== exp[i-1]) begin
                    n_bad++;
                    $display("FAIL lock_rvalid[%0d]: got %b want %b",
                             i, rvalid, exp[i-1]);
                end
            end
            tick();
        end
        req = 2'b00;
        lock = 2'b00;
        tick();
    endtask

    task automatic test_lock_release;
        logic [1:0] lk [3];
        logic [1:0] exp [3];
        lk  = '{2'b10, 2'b00, 2'b00};
        exp = '{2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            req = 2'b11;
            lock = lk[i];
            #1;
            n_cmp++;
            if (gnt !== exp[i]) begin
                n_bad++;
                $display("FAIL rel_gnt[%0d]: got %b want %b", i, gnt, exp[i]);
            end
            tick();
        end
        req = 2'b00;
        lock = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid;
        req = 2'b01;
        lock = 2'b00;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL rm_gnt_a: got %b want 01", gnt);
        end
        tick();
        lock = 2'b01;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL rm_gnt_b: got %b want 01", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rvalid !== 2'b00) begin
            n_bad++;
            $display("FAIL rm_async_rvalid: got %b want 00", rvalid);
        end
        tick();
        rst = 1'b0;
        req = 2'b00;
        lock = 2'b00;
        #1;
        n_cmp++;
        if (rvalid !== 2'b00 || gnt !== 2'b00) begin
            n_bad++;
            $display("FAIL rm_after: got rvalid=%b gnt=%b want 00 00", rvalid, gnt);
        end
        req = 2'b11;
        #1;
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_bad++;
            $display("FAIL rm_ptr: got %b want 01", gnt);
        end
        tick();
        req = 2'b00;
        tick();
    endtask

`ifdef TB_MEM_ARB_STATS_EN
    task automatic test_stats;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (stat_gnt !== 64'h0 || stat_forced !== 16'h0) begin
            n_bad++;
            $display("FAIL stat_reset: got %h %h want 0 0", stat_gnt, stat_forced);
        end
        req = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        req = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        req = 2'b00;
        #1;
        n_cmp++;
        if (stat_gnt !== {32'd3, 32'd10}) begin
            n_bad++;
            $display("FAIL stat_gnt: got %h want 000000030000000a", stat_gnt);
        end
        req = 2'b11;
        lock = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        req = 2'b00;
        lock = 2'b00;
        tick();
        n_cmp++;
        if (stat_forced !== 16'd1) begin
            n_bad++;
            $display("FAIL stat_forced: got %0d want 1", stat_forced);
        end
    endtask
`endif

    initial begin
        sram[15'h800] = 64'h539;
        sram[15'h10]  = 64'hAABB_CCDD_0000_0000;
        test_reset();
        test_read();
        test_rotation();
        test_write_read();
        test_lock();
        test_lock_release();
        test_reset_mid();
`ifdef TB_MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
